// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// =============================================================================
// data_mem_responder_pkg : shared types/constants for the data-memory responder
// Revision 1.0
// =============================================================================
package data_mem_responder_pkg;

  localparam int DMR_DATA_W  = 32;
  localparam int DMR_ADDR_W  = 10;
  localparam int DMR_LATENCY = 2;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Word index of a byte address; bits above the array depth alias away.
  function automatic logic [31:0] word_index(input logic [31:0] addr, input int aw);
    return (addr >> 2) & ((32'd1 << aw) - 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// =============================================================================
// data_mem_responder_if : request/response bus between MEM stage and responder
// Revision 1.0
// =============================================================================
interface data_mem_responder_if
  import data_mem_responder_pkg::*;
#(
  parameter int DATA_W = DMR_DATA_W
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder_dmem_ram.sv
`default_nettype none
// =============================================================================
// dmem_ram : single-port word array, synchronous write, asynchronous read
// Revision 1.0
// =============================================================================
module dmem_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];
endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// =============================================================================
// data_mem_responder : fixed-latency load/store responder for the MEM stage
// Revision 1.0
// =============================================================================
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DATA_W  = DMR_DATA_W,
  parameter int ADDR_W  = DMR_ADDR_W,
  parameter int LATENCY = DMR_LATENCY
) (
  input  logic                clk,
  input  logic                rst,
  data_mem_responder_if.slave bus
);
  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              lat_write, lat_err;
  logic [ADDR_W-1:0] lat_idx, req_idx, cur_idx;
  logic              req_err, cur_write, cur_err;
  logic              ready, accept, ram_we, resp_now;
  logic [DATA_W-1:0] ram_rdata;
  logic              resp_valid_q, resp_err_q;
  logic [DATA_W-1:0] resp_rdata_q;

  assign req_idx = ADDR_W'(word_index(bus.req_addr, ADDR_W));
  assign req_err = |bus.req_addr[1:0];
  assign ready   = (state == ST_IDLE) && !rst;
  assign accept  = bus.req_valid && ready;
  assign ram_we  = accept && bus.req_write && !req_err;

  // While idle the live request addresses the array (commit and LATENCY=1 reads);
  // once accepted the latched copy takes over.
  assign cur_idx   = (state == ST_IDLE) ? req_idx       : lat_idx;
  assign cur_write = (state == ST_IDLE) ? bus.req_write : lat_write;
  assign cur_err   = (state == ST_IDLE) ? req_err       : lat_err;

  dmem_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (cur_idx),
    .wdata (bus.req_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          cnt_nxt   = CNT_W'(LATENCY - 1);
          state_nxt = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign resp_now = (state_nxt == ST_RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      lat_write    <= 1'b0;
      lat_err      <= 1'b0;
      lat_idx      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        lat_write <= bus.req_write;
        lat_err   <= req_err;
        lat_idx   <= req_idx;
      end
      resp_valid_q <= resp_now;
      resp_err_q   <= resp_now && cur_err;
      resp_rdata_q <= (resp_now && !cur_write && !cur_err) ? ram_rdata : '0;
    end
  end

  assign bus.req_ready  = ready;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// =============================================================================
// tb_data_mem_responder : randomized + directed bench, three latency variants
// Revision 1.0
// =============================================================================
module tb_data_mem_responder;
  localparam int NDUT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [NDUT];
  logic        req_valid  [NDUT];
  logic        req_write  [NDUT];
  logic [31:0] req_addr   [NDUT];
  logic [31:0] req_wdata  [NDUT];
  logic        req_ready  [NDUT];
  logic        resp_valid [NDUT];
  logic [31:0] resp_rdata [NDUT];
  logic        resp_err   [NDUT];
  logic        busy       [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    data_mem_responder_if #(.DATA_W(32)) bus ();
    assign bus.req_valid = req_valid[g];
    assign bus.req_write = req_write[g];
    assign bus.req_addr  = req_addr[g];
    assign bus.req_wdata = req_wdata[g];
    assign req_ready[g]  = bus.req_ready;
    assign resp_valid[g] = bus.resp_valid;
    assign resp_rdata[g] = bus.resp_rdata;
    assign resp_err[g]   = bus.resp_err;
    assign busy[g]       = bus.busy;

    data_mem_responder #(
      .DATA_W  (32),
      .ADDR_W  (10),
      .LATENCY ((g == 0) ? 2 : ((g == 1) ? 1 : 15))
    ) dut (
      .clk (clk),
      .rst (rst[g]),
      .bus (bus.slave)
    );
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 15);
  endfunction

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit check_en = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Behavioural model: each accepted request occupies the responder for
  // LATENCY cycles, the last of which is the response cycle.
  logic [31:0] mem [int];
  int          busy_left [NDUT];
  logic [31:0] e_rdata   [NDUT];
  logic        e_err     [NDUT];
  bit          e_known   [NDUT];
  int          resp_cnt  [NDUT];
  int          key;

  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < NDUT; d++) begin
      if (rst[d]) begin
        busy_left[d] = 0;
      end else if (busy_left[d] == 0) begin
        if (req_valid[d]) begin
          key          = d * 4096 + int'((req_addr[d] >> 2) % 1024);
          busy_left[d] = lat_of(d);
          e_err[d]     = (req_addr[d] % 4) != 0;
          e_known[d]   = 1'b1;
          e_rdata[d]   = 32'd0;
          if (req_write[d]) begin
            if (!e_err[d]) mem[key] = req_wdata[d];
          end else if (!e_err[d]) begin
            if (mem.exists(key)) e_rdata[d] = mem[key];
            else e_known[d] = 1'b0;
          end
        end
      end else begin
        busy_left[d] = busy_left[d] - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      for (int d = 0; d < NDUT; d++) begin
        chk($sformatf("req_ready[%0d]", d), 32'(req_ready[d]), 32'((busy_left[d] == 0) && !rst[d]));
        chk($sformatf("busy[%0d]", d), 32'(busy[d]), 32'(busy_left[d] != 0));
        chk($sformatf("resp_valid[%0d]", d), 32'(resp_valid[d]), 32'(busy_left[d] == 1));
        if (busy_left[d] == 1) begin
          chk($sformatf("resp_err[%0d]", d), 32'(resp_err[d]), 32'(e_err[d]));
          if (e_known[d]) chk($sformatf("resp_rdata[%0d]", d), resp_rdata[d], e_rdata[d]);
        end else begin
          chk($sformatf("idle_rdata[%0d]", d), resp_rdata[d], 32'd0);
          chk($sformatf("idle_err[%0d]", d), 32'(resp_err[d]), 32'd0);
        end
        if (resp_valid[d] === 1'b1) resp_cnt[d]++;
      end
    end
  end

  // All tasks start and end just after a falling edge.
  task automatic issue(input int d, input bit w, input logic [31:0] a,
                       input logic [31:0] wd, output int acc_cyc);
    int n = 0;
    req_valid[d] = 1'b1;
    req_write[d] = w;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    while (req_ready[d] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      chk("accept_timeout", 32'(n), 32'd0);
      req_valid[d] = 1'b0;
    end
    acc_cyc = cyc;
    @(negedge clk);
  endtask

  task automatic get_resp(input int d, output logic [31:0] rd, output logic er, output int rc);
    int n = 0;
    while (resp_valid[d] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("resp_timeout", 32'(n), 32'd0);
    rd = resp_rdata[d];
    er = resp_err[d];
    rc = cyc;
    @(negedge clk);
  endtask

  task automatic op(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                    output logic [31:0] rd, output logic er);
    int ac, rc;
    issue(d, w, a, wd, ac);
    req_valid[d] = 1'b0;
    if (lat_of(d) == 1) begin
      rd = resp_rdata[d];
      er = resp_err[d];
      rc = (resp_valid[d] === 1'b1) ? cyc : -1;
      @(negedge clk);
    end else begin
      get_resp(d, rd, er, rc);
    end
    chk($sformatf("latency[%0d]", d), 32'(rc - ac), 32'(lat_of(d)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  logic [31:0] rd;
  logic        er;
  int          a0, a1, a2, rc0;

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_write[d] = 1'b0;
      req_addr[d] = '0; req_wdata[d] = '0;
      busy_left[d] = 0; e_rdata[d] = '0; e_err[d] = 1'b0; e_known[d] = 1'b0; resp_cnt[d] = 0;
    end
    @(posedge clk);
    @(negedge clk);
    check_en = 1'b1;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) rst[d] = 1'b0;
    @(negedge clk);

    // Reset while idle.
    rst[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready[0]), 32'd0);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    rst[0] = 1'b0;
    #1;
    chk("ready_after_rst", 32'(req_ready[0]), 32'd1);
    @(negedge clk);

    // Store then load.
    op(0, 1'b1, 32'h10, 32'hDEADBEEF, rd, er);
    chk("store_rdata", rd, 32'd0);
    chk("store_err", 32'(er), 32'd0);
    op(0, 1'b0, 32'h10, 32'h0, rd, er);
    chk("load_10", rd, 32'hDEADBEEF);
    chk("load_10_err", 32'(er), 32'd0);

    // Misaligned store leaves the word untouched.
    op(0, 1'b1, 32'h20, 32'h13579BDF, rd, er);
    op(0, 1'b1, 32'h22, 32'h00001234, rd, er);
    chk("misal_err", 32'(er), 32'd1);
    chk("misal_rdata", rd, 32'd0);
    op(0, 1'b0, 32'h20, 32'h0, rd, er);
    chk("load_20_unchanged", rd, 32'h13579BDF);

    // Aliasing and top word.
    op(0, 1'b1, 32'h1000, 32'hA5A5A5A5, rd, er);
    chk("alias_err", 32'(er), 32'd0);
    op(0, 1'b0, 32'h0, 32'h0, rd, er);
    chk("alias_load_0", rd, 32'hA5A5A5A5);
    op(0, 1'b1, 32'hFFC, 32'hC0FFEE01, rd, er);
    op(0, 1'b0, 32'h1FFC, 32'h0, rd, er);
    chk("word1023_alias", rd, 32'hC0FFEE01);

    // Continuous req_valid across three requests.
    rc0 = resp_cnt[0];
    issue(0, 1'b0, 32'h10, 32'h0, a0);
    issue(0, 1'b1, 32'h14, 32'h00000099, a1);
    issue(0, 1'b0, 32'h14, 32'h0, a2);
    req_valid[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("spacing01", 32'(a1 - a0), 32'd3);
    chk("spacing12", 32'(a2 - a1), 32'd3);
    chk("pulses_b2b", 32'(resp_cnt[0] - rc0), 32'd3);

    // Reset during an outstanding store, each latency variant.
    for (int d = 0; d < NDUT; d++) begin
      rc0 = resp_cnt[d];
      issue(d, 1'b1, 32'h40, 32'h00000055, a0);
      req_valid[d] = 1'b0;
      if (d == 2) repeat (3) @(negedge clk);
      rst[d] = 1'b1;
      repeat (2) @(negedge clk);
      rst[d] = 1'b0;
      repeat (lat_of(d) + 2) @(negedge clk);
      chk($sformatf("midrst_pulses[%0d]", d), 32'(resp_cnt[d] - rc0), (d == 1) ? 32'd1 : 32'd0);
      op(d, 1'b0, 32'h40, 32'h0, rd, er);
      chk($sformatf("midrst_load[%0d]", d), rd, 32'h00000055);
    end

    // Randomized traffic on the LATENCY=2 instance.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 15) << 2) | ($urandom_range(0, 3) << 12);
      if ($urandom_range(0, 3) == 0) a = a | $urandom_range(1, 3);
      issue(0, 1'($urandom_range(0, 1)), a, $urandom, a0);
      if ($urandom_range(0, 1) == 1) begin
        req_valid[0] = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    req_valid[0] = 1'b0;
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
